rule_conf_writer: RTL

//   Initiator side of the 32b rule-configuration bus. Accepts one complete

---
 rtl/rule_conf_writer_pkg.sv | 44 ++++
 rtl/rule_conf_writer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rule_conf_writer_pkg.sv
// rtl/rule_conf_writer_pkg.sv - rule table types, config-bus selectors and address helper
package rule_conf_writer_pkg;

    localparam int TYPE_NUM          = 4;
    localparam int TYPE_WIDTH        = 16;
    localparam int TYPE_OFFSET_WIDTH = 8;
    localparam int KEY_FILED_NUM     = 6;
    localparam int KEY_OFFSET_WIDTH  = 6;
    localparam int HEAD_SHIFT_WIDTH  = 6;
    localparam int META_SHIFT_WIDTH  = 6;
    localparam int RULE_NUM          = 16;
    localparam int CONF_WR_NUM       = 2*TYPE_NUM + KEY_FILED_NUM + 3;

    // keyOffset MSB is the per-field valid flag, the rest is the offset.
    typedef struct packed {
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          typeData;
        logic [TYPE_NUM-1:0][TYPE_WIDTH-1:0]          typeMask;
        logic [TYPE_NUM-1:0][TYPE_OFFSET_WIDTH-1:0]   typeOffset;
        logic [KEY_FILED_NUM-1:0][KEY_OFFSET_WIDTH:0] keyOffset;
        logic [HEAD_SHIFT_WIDTH-1:0]                  headShift;
        logic [META_SHIFT_WIDTH-1:0]                  metaShift;
        logic                                         typeRule_valid;
    } type_rule_t;

    typedef enum logic [2:0] {
        SEL_RULE = 3'd0,
        SEL_TYPE = 3'd1,
        SEL_TOFF = 3'd2,
        SEL_KEY  = 3'd3,
        SEL_HEAD = 3'd4,
        SEL_META = 3'd5
    } conf_sel_e;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
    } conf_wr_t;

    function automatic logic [31:0] conf_addr(input logic [31:0] base, input conf_sel_e sel,
                                              input logic [5:0] idx);
        return {base[31:11], sel, 2'b00, idx};
    endfunction

endpackage

// File: rtl/rule_conf_writer.sv
// rtl/rule_conf_writer.sv - serialises one type_rule_t into ordered rule-config bus writes
// Optional feature: RULE_CONF_WR_CNT_EN adds the saturating o_wr_cnt write counter.
module rule_conf_writer
    import rule_conf_writer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          WR_GAP    = 0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [5:0]  i_rule_id,
    input  type_rule_t  i_type_rule,
    output logic        o_rule_wren,
    output logic [31:0] o_rule_addr,
    output logic [31:0] o_rule_wdata,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
`ifdef RULE_CONF_WR_CNT_EN
    ,
    output logic [31:0] o_wr_cnt
`endif
);

    localparam int TIDX_W = $clog2(TYPE_NUM);
    localparam int KIDX_W = $clog2(KEY_FILED_NUM);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TYPE,
        ST_TOFF,
        ST_KEY,
        ST_HEAD,
        ST_META,
        ST_COMMIT,
        ST_DONE
    } wr_state_e;

    wr_state_e  state;
    wr_state_e  nxt_state;
    logic [5:0] idx;
    logic [5:0] nxt_idx;
    logic [3:0] gap;
    type_rule_t snap_rule;
    logic [5:0] snap_id;
    logic       accept;
    logic       id_bad;
    logic       slot_due;
    logic       wr_issue;
    conf_wr_t   acc_wr;
    conf_wr_t   nxt_wr;
    conf_wr_t   issue_wr;

    function automatic conf_wr_t format_wr(input wr_state_e st, input logic [5:0] i,
                                           input type_rule_t r, input logic [5:0] id);
        conf_wr_t w;
        w.addr  = '0;
        w.wdata = '0;
        case (st)
            ST_TYPE: begin
                w.addr = conf_addr(BASE_ADDR, SEL_TYPE, i);
                w.wdata[16+:TYPE_WIDTH] = r.typeData[i[TIDX_W-1:0]];
                w.wdata[0+:TYPE_WIDTH]  = r.typeMask[i[TIDX_W-1:0]];
            end
            ST_TOFF: begin
                w.addr = conf_addr(BASE_ADDR, SEL_TOFF, i);
                w.wdata[0+:TYPE_OFFSET_WIDTH] = r.typeOffset[i[TIDX_W-1:0]];
            end
            ST_KEY: begin
                w.addr = conf_addr(BASE_ADDR, SEL_KEY, i);
                w.wdata[16] = r.keyOffset[i[KIDX_W-1:0]][KEY_OFFSET_WIDTH];
                w.wdata[0+:KEY_OFFSET_WIDTH] = r.keyOffset[i[KIDX_W-1:0]][KEY_OFFSET_WIDTH-1:0];
            end
            ST_HEAD: begin
                w.addr = conf_addr(BASE_ADDR, SEL_HEAD, 6'd0);
                w.wdata[0+:HEAD_SHIFT_WIDTH] = r.headShift;
            end
            ST_META: begin
                w.addr = conf_addr(BASE_ADDR, SEL_META, 6'd0);
                w.wdata[0+:META_SHIFT_WIDTH] = r.metaShift;
            end
            ST_COMMIT: begin
                w.addr = conf_addr(BASE_ADDR, SEL_RULE, id);
                w.wdata[0] = r.typeRule_valid;
            end
            default: begin
                w.addr  = '0;
                w.wdata = '0;
            end
        endcase
        return w;
    endfunction

    assign accept   = (state == ST_IDLE) && i_req_valid && o_req_ready;
    assign id_bad   = (snap_id >= 6'(RULE_NUM));
    assign slot_due = (state inside {ST_TYPE, ST_TOFF, ST_KEY, ST_HEAD, ST_META, ST_COMMIT})
                      && (gap == 4'd0);

    // Slot that follows the write currently on the bus.
    always_comb begin
        nxt_state = state;
        nxt_idx   = idx;
        case (state)
            ST_TYPE: begin
                if (idx == 6'(TYPE_NUM-1)) begin
                    nxt_state = ST_TOFF;
                    nxt_idx   = 6'd0;
                end else begin
                    nxt_idx = idx + 6'd1;
                end
            end
            ST_TOFF: begin
                if (idx == 6'(TYPE_NUM-1)) begin
                    nxt_state = ST_KEY;
                    nxt_idx   = 6'd0;
                end else begin
                    nxt_idx = idx + 6'd1;
                end
            end
            ST_KEY: begin
                if (idx == 6'(KEY_FILED_NUM-1)) begin
                    nxt_state = ST_HEAD;
                    nxt_idx   = 6'd0;
                end else begin
                    nxt_idx = idx + 6'd1;
                end
            end
            ST_HEAD:   nxt_state = ST_META;
            ST_META:   nxt_state = ST_COMMIT;
            ST_COMMIT: nxt_state = ST_DONE;
            default: begin
                nxt_state = state;
                nxt_idx   = idx;
            end
        endcase
    end

    // The first write is formatted straight from the inputs so it can go out
    // the cycle after accept; later writes come from the snapshot.
    always_comb begin
        acc_wr   = format_wr(ST_TYPE, 6'd0, i_type_rule, i_rule_id);
        nxt_wr   = format_wr(nxt_state, nxt_idx, snap_rule, snap_id);
        issue_wr = accept ? acc_wr : nxt_wr;
        wr_issue = accept || (slot_due && (nxt_state != ST_DONE)
                              && !((nxt_state == ST_COMMIT) && id_bad));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            idx          <= 6'd0;
            gap          <= 4'd0;
            snap_rule    <= '0;
            snap_id      <= 6'd0;
            o_req_ready  <= 1'b1;
            o_rule_wren  <= 1'b0;
            o_rule_addr  <= 32'd0;
            o_rule_wdata <= 32'd0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_rule_wren <= wr_issue;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            if (wr_issue) begin
                o_rule_addr  <= issue_wr.addr;
                o_rule_wdata <= issue_wr.wdata;
            end
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        snap_rule   <= i_type_rule;
                        snap_id     <= i_rule_id;
                        state       <= ST_TYPE;
                        idx         <= 6'd0;
                        gap         <= 4'(WR_GAP);
                        o_req_ready <= 1'b0;
                        o_busy      <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_busy      <= 1'b0;
                    o_req_ready <= 1'b1;
                end
                default: begin
                    if (gap != 4'd0) begin
                        gap <= gap - 4'd1;
                    end else begin
                        state <= nxt_state;
                        idx   <= nxt_idx;
                        gap   <= 4'(WR_GAP);
                        if (nxt_state == ST_DONE) begin
                            o_done <= 1'b1;
                            o_err  <= id_bad;
                        end
                    end
                end
            endcase
        end
    end

`ifdef RULE_CONF_WR_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_cnt <= 32'd0;
        end else if (wr_issue && (o_wr_cnt != 32'hFFFF_FFFF)) begin
            o_wr_cnt <= o_wr_cnt + 32'd1;
        end
    end
`endif

endmodule
